alarm_ctrl: RTL and testbench

- Alarm controller alongside the time-keeping counter chain and its run/set controller.
- Holds a programmable alarm time (hr:min) and lets the user edit it with the shared synchronized buttons.
- Compares the alarm time against the live hr/min counter values and sequences ring, snooze and auto-stop, all timed by the seconds tick from the counter chain.

---
 rtl/alarm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an editable alarm time, watches the live hr/min
// counters for a fresh match and sequences ring, snooze and auto-stop using
// the one-per-second tick from the counter chain.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_set,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_en_toggle,
    input  logic       i_snooze,
    input  logic       i_stop,
    input  logic       i_sec_tick,
    input  logic [4:0] i_cur_hr,
    input  logic [5:0] i_cur_min,
    output logic [4:0] o_alarm_hr,
    output logic [5:0] o_alarm_min,
    output logic       o_alarm_en,
    output logic       o_ringing,
    output logic [2:0] o_state,
    output logic [2:0] o_snooze_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_HR  = 3'd2,
        RING    = 3'd3,
        SNOOZE  = 3'd4
    } state_t;

    localparam logic [7:0]  RING_LIM    = 8'(RING_SECS);
    localparam logic [10:0] SNOOZE_LIM  = 11'(SNOOZE_MINS * 60);
    localparam logic [2:0]  SNOOZE_INIT = 3'(MAX_SNOOZE);

    state_t      r_state;
    logic [4:0]  r_alarm_hr;
    logic [5:0]  r_alarm_min;
    logic        r_alarm_en;
    logic [2:0]  r_snooze_left;
    logic [7:0]  r_ring_cnt;
    logic [10:0] r_snooze_cnt;
    logic        r_match_d;

    logic        w_match;
    logic        w_trigger;
    logic [5:0]  w_min_edit;
    logic [4:0]  w_hr_edit;

    // A trigger is the first cycle of an alarm-time match while armed and idle,
    // so a match already present when arming or leaving set mode never fires.
    always_comb begin
        w_match   = (i_cur_hr == r_alarm_hr) && (i_cur_min == r_alarm_min);
        w_trigger = w_match && !r_match_d && r_alarm_en && (r_state == IDLE);
    end

    // Candidate edited values for both fields; up+down together clears the field.
    always_comb begin
        w_min_edit = r_alarm_min;
        w_hr_edit  = r_alarm_hr;
        if (i_up && i_down) begin
            w_min_edit = 6'd0;
            w_hr_edit  = 5'd0;
        end else if (i_up) begin
            w_min_edit = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
            w_hr_edit  = (r_alarm_hr == 5'd23) ? 5'd0 : r_alarm_hr + 5'd1;
        end else if (i_down) begin
            w_min_edit = (r_alarm_min == 6'd0) ? 6'd59 : r_alarm_min - 6'd1;
            w_hr_edit  = (r_alarm_hr == 5'd0) ? 5'd23 : r_alarm_hr - 5'd1;
        end
    end

    // Main controller: state, alarm time, enable, snooze budget and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_alarm_hr    <= 5'd0;
            r_alarm_min   <= 6'd0;
            r_alarm_en    <= 1'b0;
            r_snooze_left <= SNOOZE_INIT;
            r_ring_cnt    <= 8'd0;
            r_snooze_cnt  <= 11'd0;
            r_match_d     <= 1'b0;
        end else begin
            r_match_d <= w_match;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state       <= RING;
                        r_ring_cnt    <= 8'd0;
                        r_snooze_cnt  <= 11'd0;
                        r_snooze_left <= SNOOZE_INIT;
                    end else if (i_set) begin
                        r_state <= SET_MIN;
                    end
                    if (i_en_toggle) begin
                        r_alarm_en <= !r_alarm_en;
                    end
                end
                SET_MIN, SET_HR: begin
                    if (i_set) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_state == SET_MIN) begin
                            r_alarm_min <= w_min_edit;
                        end else begin
                            r_alarm_hr <= w_hr_edit;
                        end
                        if (i_left || i_right) begin
                            r_state <= (r_state == SET_MIN) ? SET_HR : SET_MIN;
                        end
                    end
                end
                RING: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (i_en_toggle) begin
                        r_state    <= IDLE;
                        r_alarm_en <= 1'b0;
                    end else if (i_snooze) begin
                        if (r_snooze_left != 3'd0) begin
                            r_state       <= SNOOZE;
                            r_snooze_left <= r_snooze_left - 3'd1;
                            r_snooze_cnt  <= 11'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (i_sec_tick) begin
                        if (r_ring_cnt + 8'd1 == RING_LIM) begin
                            r_state <= IDLE;
                        end
                        r_ring_cnt <= r_ring_cnt + 8'd1;
                    end
                end
                SNOOZE: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (i_en_toggle) begin
                        r_state    <= IDLE;
                        r_alarm_en <= 1'b0;
                    end else if (i_sec_tick) begin
                        if (r_snooze_cnt + 11'd1 == SNOOZE_LIM) begin
                            r_state    <= RING;
                            r_ring_cnt <= 8'd0;
                        end
                        r_snooze_cnt <= r_snooze_cnt + 11'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are the registers themselves; the buzzer is a decode of RING.
    always_comb begin
        o_alarm_hr    = r_alarm_hr;
        o_alarm_min   = r_alarm_min;
        o_alarm_en    = r_alarm_en;
        o_state       = r_state;
        o_snooze_left = r_snooze_left;
        o_ringing     = (r_state == RING);
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: directed button/tick sequences with literal
// expectations, plus a behavioural model compared on every clock.
module tb_alarm_ctrl;

    localparam int RING_SECS   = 4;
    localparam int SNOOZE_MINS = 1;
    localparam int MAX_SNOOZE  = 1;

    localparam int P_SET   = 1;
    localparam int P_UP    = 2;
    localparam int P_DOWN  = 4;
    localparam int P_LEFT  = 8;
    localparam int P_RIGHT = 16;
    localparam int P_EN    = 32;
    localparam int P_SNZ   = 64;
    localparam int P_STOP  = 128;
    localparam int P_TICK  = 256;

    logic       clk;
    logic       rst;
    logic       setBtn, upBtn, downBtn, leftBtn, rightBtn;
    logic       enToggle, snoozeBtn, stopBtn, secTick;
    logic [4:0] curHr;
    logic [5:0] curMin;
    logic [4:0] alarmHr;
    logic [5:0] alarmMin;
    logic       alarmEn;
    logic       ringing;
    logic [2:0] state;
    logic [2:0] snoozeLeft;

    int errCount   = 0;
    int checkCount = 0;

    // Model variables: plain integers describing what the outputs must be.
    int  mState, mHr, mMin, mEn, mLeft, mRingSecs, mSnoozeSecs;
    bit  mPrevMatch;
    bit  modelValid = 0;

    alarm_ctrl #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_MINS(SNOOZE_MINS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_set        (setBtn),
        .i_up         (upBtn),
        .i_down       (downBtn),
        .i_left       (leftBtn),
        .i_right      (rightBtn),
        .i_en_toggle  (enToggle),
        .i_snooze     (snoozeBtn),
        .i_stop       (stopBtn),
        .i_sec_tick   (secTick),
        .i_cur_hr     (curHr),
        .i_cur_min    (curMin),
        .o_alarm_hr   (alarmHr),
        .o_alarm_min  (alarmMin),
        .o_alarm_en   (alarmEn),
        .o_ringing    (ringing),
        .o_state      (state),
        .o_snooze_left(snoozeLeft)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of pulses starting at a falling edge; returns at the next
    // falling edge with all pulses released, after the DUT has sampled them.
    task automatic applyStimulus(input int pulses);
        setBtn    = (pulses & P_SET)   != 0;
        upBtn     = (pulses & P_UP)    != 0;
        downBtn   = (pulses & P_DOWN)  != 0;
        leftBtn   = (pulses & P_LEFT)  != 0;
        rightBtn  = (pulses & P_RIGHT) != 0;
        enToggle  = (pulses & P_EN)    != 0;
        snoozeBtn = (pulses & P_SNZ)   != 0;
        stopBtn   = (pulses & P_STOP)  != 0;
        secTick   = (pulses & P_TICK)  != 0;
        @(negedge clk);
        {setBtn, upBtn, downBtn, leftBtn, rightBtn} = '0;
        {enToggle, snoozeBtn, stopBtn, secTick}     = '0;
    endtask

    task automatic repeatStimulus(input int pulses, input int n);
        for (int i = 0; i < n; i++) applyStimulus(pulses);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setCur(input int hr, input int mn);
        curHr  = 5'(hr);
        curMin = 6'(mn);
    endtask

    // Behavioural model advanced on each rising edge, then compared 1 time unit later.
    always @(posedge clk) begin
        bit match;
        match = (int'(curHr) == mHr) && (int'(curMin) == mMin);
        if (rst) begin
            mState = 0; mHr = 0; mMin = 0; mEn = 0; mLeft = MAX_SNOOZE;
            mRingSecs = 0; mSnoozeSecs = 0; mPrevMatch = 0;
            modelValid = 1;
        end else if (modelValid) begin
            if (mState == 0) begin
                if (match && !mPrevMatch && mEn == 1) begin
                    mState = 3; mRingSecs = 0; mSnoozeSecs = 0; mLeft = MAX_SNOOZE;
                end else if (setBtn) begin
                    mState = 1;
                end
                if (enToggle) mEn = 1 - mEn;
            end else if (mState == 1 || mState == 2) begin
                if (setBtn) begin
                    mState = 0;
                end else begin
                    int modulus;
                    int field;
                    modulus = (mState == 1) ? 60 : 24;
                    field   = (mState == 1) ? mMin : mHr;
                    if (upBtn && downBtn) field = 0;
                    else if (upBtn)       field = (field + 1) % modulus;
                    else if (downBtn)     field = (field + modulus - 1) % modulus;
                    if (mState == 1) mMin = field; else mHr = field;
                    if (leftBtn || rightBtn) mState = 3 - mState;
                end
            end else if (mState == 3) begin
                if (stopBtn) mState = 0;
                else if (enToggle) begin mState = 0; mEn = 0; end
                else if (snoozeBtn) begin
                    if (mLeft > 0) begin mState = 4; mLeft--; mSnoozeSecs = 0; end
                    else mState = 0;
                end else if (secTick) begin
                    mRingSecs++;
                    if (mRingSecs >= RING_SECS) mState = 0;
                end
            end else if (mState == 4) begin
                if (stopBtn) mState = 0;
                else if (enToggle) begin mState = 0; mEn = 0; end
                else if (secTick) begin
                    mSnoozeSecs++;
                    if (mSnoozeSecs == SNOOZE_MINS * 60) begin mState = 3; mRingSecs = 0; end
                end
            end
        end
        mPrevMatch = match && !rst;
        #1;
        if (modelValid) begin
            checkOutput("model.state",  32'(state),      32'(mState));
            checkOutput("model.hr",     32'(alarmHr),    32'(mHr));
            checkOutput("model.min",    32'(alarmMin),   32'(mMin));
            checkOutput("model.en",     32'(alarmEn),    32'(mEn));
            checkOutput("model.ring",   32'(ringing),    32'(mState == 3));
            checkOutput("model.snzLeft", 32'(snoozeLeft), 32'(mLeft));
        end
    end

    // Directed sequence following the test plan, with literal expectations.
    initial begin
        rst = 1'b1;
        {setBtn, upBtn, downBtn, leftBtn, rightBtn} = '0;
        {enToggle, snoozeBtn, stopBtn, secTick}     = '0;
        setCur(12, 30);
        @(negedge clk);
        doReset();
        checkOutput("reset.state", 32'(state), 0);
        checkOutput("reset.hr", 32'(alarmHr), 0);
        checkOutput("reset.min", 32'(alarmMin), 0);
        checkOutput("reset.en", 32'(alarmEn), 0);
        checkOutput("reset.ring", 32'(ringing), 0);
        checkOutput("reset.snzLeft", 32'(snoozeLeft), MAX_SNOOZE);

        // Program 06:07.
        applyStimulus(P_SET);
        checkOutput("set.enterMin", 32'(state), 1);
        repeatStimulus(P_UP, 7);
        applyStimulus(P_RIGHT);
        checkOutput("set.toHr", 32'(state), 2);
        repeatStimulus(P_UP, 6);
        applyStimulus(P_SET);
        checkOutput("set.min", 32'(alarmMin), 7);
        checkOutput("set.hr", 32'(alarmHr), 6);
        checkOutput("set.exitState", 32'(state), 0);
        checkOutput("set.en", 32'(alarmEn), 0);

        // Wrap and clear on both fields.
        applyStimulus(P_SET);
        applyStimulus(P_UP | P_DOWN);
        checkOutput("wrap.minClear", 32'(alarmMin), 0);
        applyStimulus(P_DOWN);
        checkOutput("wrap.minDown", 32'(alarmMin), 59);
        applyStimulus(P_UP);
        checkOutput("wrap.minUp", 32'(alarmMin), 0);
        applyStimulus(P_RIGHT);
        applyStimulus(P_UP | P_DOWN);
        checkOutput("wrap.hrClear", 32'(alarmHr), 0);
        applyStimulus(P_DOWN);
        checkOutput("wrap.hrDown", 32'(alarmHr), 23);
        applyStimulus(P_UP);
        checkOutput("wrap.hrUp", 32'(alarmHr), 0);
        repeatStimulus(P_UP, 6);
        applyStimulus(P_LEFT);
        checkOutput("wrap.toMin", 32'(state), 1);
        repeatStimulus(P_UP, 7);
        applyStimulus(P_SET | P_UP);
        checkOutput("setPrio.min", 32'(alarmMin), 7);
        checkOutput("setPrio.state", 32'(state), 0);

        // Trigger on the rising match, no retrigger while the match is held.
        applyStimulus(P_EN);
        checkOutput("trig.en", 32'(alarmEn), 1);
        setCur(6, 6);
        applyStimulus(0);
        checkOutput("trig.before", 32'(ringing), 0);
        setCur(6, 7);
        applyStimulus(0);
        checkOutput("trig.ring", 32'(ringing), 1);
        repeatStimulus(0, 3);
        applyStimulus(P_STOP);
        checkOutput("trig.stop", 32'(ringing), 0);
        repeatStimulus(0, 3);
        checkOutput("trig.noRetrig", 32'(state), 0);

        // Auto-stop after RING_SECS ticks.
        setCur(6, 8);
        applyStimulus(0);
        setCur(6, 7);
        applyStimulus(0);
        checkOutput("auto.ring", 32'(ringing), 1);
        applyStimulus(P_TICK);
        checkOutput("auto.oneTick", 32'(ringing), 1);
        repeatStimulus(P_TICK, 2);
        checkOutput("auto.threeTicks", 32'(ringing), 1);
        applyStimulus(P_TICK);
        checkOutput("auto.fourthTick", 32'(ringing), 0);

        // Snooze, wake after one minute, snooze with budget exhausted stops.
        setCur(6, 8);
        applyStimulus(0);
        setCur(6, 7);
        applyStimulus(0);
        applyStimulus(P_SNZ);
        checkOutput("snz.state", 32'(state), 4);
        checkOutput("snz.left", 32'(snoozeLeft), 0);
        applyStimulus(P_SNZ);
        checkOutput("snz.ignored", 32'(state), 4);
        repeatStimulus(P_TICK, 59);
        checkOutput("snz.59", 32'(state), 4);
        applyStimulus(P_TICK);
        checkOutput("snz.wake", 32'(state), 3);
        applyStimulus(P_SNZ);
        checkOutput("snz.exhausted", 32'(state), 0);
        checkOutput("snz.leftKept", 32'(snoozeLeft), 0);

        // Reset mid-ring.
        setCur(6, 8);
        applyStimulus(0);
        setCur(6, 7);
        applyStimulus(0);
        checkOutput("rstRing.pre", 32'(state), 3);
        doReset();
        checkOutput("rstRing.state", 32'(state), 0);
        checkOutput("rstRing.ring", 32'(ringing), 0);
        checkOutput("rstRing.en", 32'(alarmEn), 0);
        checkOutput("rstRing.min", 32'(alarmMin), 0);
        checkOutput("rstRing.left", 32'(snoozeLeft), MAX_SNOOZE);

        // stop+snooze together: stop wins, snooze budget untouched.
        setCur(23, 59);
        applyStimulus(P_EN);
        setCur(0, 0);
        applyStimulus(0);
        checkOutput("prio.ring", 32'(state), 3);
        applyStimulus(P_STOP | P_SNZ);
        checkOutput("prio.state", 32'(state), 0);
        checkOutput("prio.left", 32'(snoozeLeft), 1);

        // Enable toggle while ringing disarms and returns to idle.
        setCur(0, 1);
        applyStimulus(0);
        setCur(0, 0);
        applyStimulus(0);
        applyStimulus(P_EN);
        checkOutput("enRing.state", 32'(state), 0);
        checkOutput("enRing.en", 32'(alarmEn), 0);

        // Arming while the match already holds must not fire.
        applyStimulus(P_EN);
        repeatStimulus(0, 2);
        checkOutput("armOnMatch.state", 32'(state), 0);
        checkOutput("armOnMatch.en", 32'(alarmEn), 1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
